// File: rtl/challenge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : challenge_pkg
// Description : Shared definitions for the challenge issuer and the response
//               checker: challenge geometry and the issuer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package challenge_pkg;

    localparam int CHALLENGE_WIDTH = 128;
    localparam int CHALLENGE_BYTES = CHALLENGE_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADVANCE = 3'd1,
        LATCH   = 3'd2,
        SEND    = 3'd3,
        SUM     = 3'd4
    } state_t;

endpackage : challenge_pkg
`default_nettype wire

// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Parallel-load shift register that presents its most
//               significant byte on a valid/ready byte stream and shifts one
//               byte per handshake, with a byte index for end detection.
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_load, i_data   - parallel load (clears the byte index)
//               i_active         - stream valid while the owner is sending
//               i_tx_ready       - sink accepts the current byte
//               o_byte           - current byte (MSB byte of the register)
//               o_fire           - handshake this cycle
//               o_last           - current byte is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer
    import challenge_pkg::*;
#(
    parameter int WIDTH = CHALLENGE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_active,
    input  logic             i_tx_ready,
    output logic [7:0]       o_byte,
    output logic             o_fire,
    output logic             o_last
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IW     = $clog2(NBYTES) + 1;

    logic [WIDTH-1:0] r_shift;
    logic [IW-1:0]    r_index;

    assign o_fire = i_active & i_tx_ready;
    assign o_byte = r_shift[WIDTH-1 -: 8];
    assign o_last = (r_index == IW'(NBYTES - 1));

    // Without a handshake the register is untouched, so the byte on the
    // stream stays stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_index <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_index <= '0;
        end else if (o_fire) begin
            r_shift <= r_shift << 8;
            r_index <= r_index + 1'b1;
        end
    end

endmodule : byte_serializer
`default_nettype wire

// File: rtl/challenge_issuer.sv
`default_nettype none
// ============================================================================
// Module      : challenge_issuer
// Description : On start, steps the external LFSR STEPS times, latches its
//               state as the current challenge and streams it MSB-byte-first
//               on a valid/ready byte interface to the UART transmitter.
//               Optional macro CHALLENGE_CHECKSUM_EN appends one XOR checksum
//               byte after the challenge bytes.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_start             - request a challenge (sampled in IDLE)
//               i_lfsr_random       - current LFSR state
//               o_lfsr_enable       - LFSR advance strobe
//               o_tx_data/o_tx_valid/i_tx_ready - byte stream to UART TX
//               o_challenge         - latched challenge for the checker
//               o_challenge_valid   - challenge fully sent and current
//               o_busy              - not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module challenge_issuer
    import challenge_pkg::*;
#(
    parameter int WIDTH = CHALLENGE_WIDTH,
    parameter int STEPS = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_lfsr_random,
    output logic             o_lfsr_enable,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic [WIDTH-1:0] o_challenge,
    output logic             o_challenge_valid,
    output logic             o_busy
);

    localparam int CW = $clog2(STEPS) + 1;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_lfsr_enable;
    logic             r_tx_valid;
    logic             r_busy;
    logic             r_challenge_valid;
    logic [WIDTH-1:0] r_challenge;

    logic             w_load;
    logic             w_active;
    logic             w_fire;
    logic             w_last;
    logic [7:0]       w_ser_byte;

    // Capture happens at the end of LATCH, when the LFSR has taken exactly
    // STEPS advances and is holding still.
    assign w_load   = (r_state == LATCH);
    assign w_active = (r_state == SEND);

    byte_serializer #(
        .WIDTH (WIDTH)
    ) u_byte_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_data     (i_lfsr_random),
        .i_active   (w_active),
        .i_tx_ready (i_tx_ready),
        .o_byte     (w_ser_byte),
        .o_fire     (w_fire),
        .o_last     (w_last)
    );

`ifdef CHALLENGE_CHECKSUM_EN
    logic [7:0] r_checksum;
    assign o_tx_data = (r_state == SUM) ? r_checksum : w_ser_byte;
`else
    assign o_tx_data = w_ser_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_count           <= '0;
            r_lfsr_enable     <= 1'b0;
            r_tx_valid        <= 1'b0;
            r_busy            <= 1'b0;
            r_challenge_valid <= 1'b0;
            r_challenge       <= '0;
`ifdef CHALLENGE_CHECKSUM_EN
            r_checksum        <= 8'h00;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state           <= ADVANCE;
                        r_count           <= CW'(STEPS - 1);
                        r_lfsr_enable     <= 1'b1;
                        r_busy            <= 1'b1;
                        r_challenge_valid <= 1'b0;
                    end
                end
                ADVANCE: begin
                    // The strobe is already high on entry, so counting
                    // STEPS-1 down to 0 yields exactly STEPS advances.
                    if (r_count == '0) begin
                        r_state       <= LATCH;
                        r_lfsr_enable <= 1'b0;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                LATCH: begin
                    r_challenge <= i_lfsr_random;
                    r_tx_valid  <= 1'b1;
                    r_state     <= SEND;
`ifdef CHALLENGE_CHECKSUM_EN
                    r_checksum  <= 8'h00;
`endif
                end
                SEND: begin
                    if (w_fire) begin
`ifdef CHALLENGE_CHECKSUM_EN
                        r_checksum <= r_checksum ^ w_ser_byte;
                        if (w_last) begin
                            r_state <= SUM;
                        end
`else
                        if (w_last) begin
                            r_state           <= IDLE;
                            r_tx_valid        <= 1'b0;
                            r_busy            <= 1'b0;
                            r_challenge_valid <= 1'b1;
                        end
`endif
                    end
                end
`ifdef CHALLENGE_CHECKSUM_EN
                SUM: begin
                    if (i_tx_ready) begin
                        r_state           <= IDLE;
                        r_tx_valid        <= 1'b0;
                        r_busy            <= 1'b0;
                        r_challenge_valid <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_lfsr_enable     = r_lfsr_enable;
    assign o_tx_valid        = r_tx_valid;
    assign o_busy            = r_busy;
    assign o_challenge_valid = r_challenge_valid;
    assign o_challenge       = r_challenge;

endmodule : challenge_issuer
`default_nettype wire

// File: tb/tb_challenge_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_challenge_issuer
// Description : Self-checking bench for challenge_issuer. A behavioural LFSR
//               drives both DUTs; a timeline/queue model predicts every
//               output cycle by cycle. Optional macro CHALLENGE_CHECKSUM_EN
//               must match the RTL build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_challenge_issuer;

    localparam int          STEPS    = 128;
    localparam int          NBYTES   = 16;
`ifdef CHALLENGE_CHECKSUM_EN
    localparam int          NB_EXP   = 17;
`else
    localparam int          NB_EXP   = 16;
`endif
    localparam logic [127:0] SEED    = 128'hACE1BABECAFEDEADBEEFFEEDFACEC0DE;
    localparam logic [127:0] SEED_S1 = 128'h59C3757D95FDBD5B7DDFFDDBF59D81BD;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         env_rst_n;
    logic         start;
    logic         tx_ready;
    logic [127:0] lfsr;
    logic         lfsr_enable;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic [127:0] challenge;
    logic         cv;
    logic         busy;

    logic         start1;
    logic         tx_ready1;
    logic [127:0] lfsr1;
    logic         en1;
    logic [7:0]   data1;
    logic         valid1;
    logic [127:0] chal1;
    logic         cv1;
    logic         busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    challenge_issuer #(.WIDTH(128), .STEPS(STEPS)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (start),
        .i_lfsr_random     (lfsr),
        .o_lfsr_enable     (lfsr_enable),
        .o_tx_data         (tx_data),
        .o_tx_valid        (tx_valid),
        .i_tx_ready        (tx_ready),
        .o_challenge       (challenge),
        .o_challenge_valid (cv),
        .o_busy            (busy)
    );

    challenge_issuer #(.WIDTH(128), .STEPS(1)) u_one (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (start1),
        .i_lfsr_random     (lfsr1),
        .o_lfsr_enable     (en1),
        .o_tx_data         (data1),
        .o_tx_valid        (valid1),
        .i_tx_ready        (tx_ready1),
        .o_challenge       (chal1),
        .o_challenge_valid (cv1),
        .o_busy            (busy1)
    );

    // XNOR feedback from taps 128,126,101,99, shifting in at the LSB.
    function automatic logic [127:0] lfsr_step(input logic [127:0] s);
        return {s[126:0], ~(s[127] ^ s[125] ^ s[100] ^ s[98])};
    endfunction

    // Free-running external LFSRs with their own reset.
    always @(posedge clk or negedge env_rst_n) begin
        if (!env_rst_n)       lfsr <= SEED;
        else if (lfsr_enable) lfsr <= lfsr_step(lfsr);
    end
    always @(posedge clk or negedge env_rst_n) begin
        if (!env_rst_n) lfsr1 <= SEED;
        else if (en1)   lfsr1 <= lfsr_step(lfsr1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_busy = 1'b0;
    logic         m_cv = 1'b0;
    logic [127:0] m_chal = '0;
    logic [127:0] m_lfsr = SEED;
    int           m_k = 0;
    logic [7:0]   q[$];
    logic         hold_prev = 1'b0;
    logic [7:0]   prev_data = 8'h00;
    int           rx_cnt = 0;
    int           en_cnt = 0;
    logic [127:0] rx = '0;
    logic [7:0]   sum_byte = 8'h00;

    initial begin : compare
        logic       was_busy;
        logic       exp_en;
        logic       exp_valid;
        logic [7:0] x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_busy",  128'(busy), 128'(0));
                chk("rst_valid", 128'(tx_valid), 128'(0));
                chk("rst_en",    128'(lfsr_enable), 128'(0));
                chk("rst_cv",    128'(cv), 128'(0));
                chk("rst_data",  128'(tx_data), 128'(0));
                chk("rst_chal",  challenge, 128'(0));
            end else begin
                exp_en    = m_busy && (m_k >= 1) && (m_k <= STEPS);
                exp_valid = m_busy && (m_k >= STEPS + 2);
                chk("lfsr_enable", 128'(lfsr_enable), 128'(exp_en));
                chk("tx_valid",    128'(tx_valid), 128'(exp_valid));
                chk("busy",        128'(busy), 128'(m_busy));
                chk("challenge_valid", 128'(cv), 128'(m_cv));
                chk("challenge",   challenge, m_chal);
                if (exp_valid && tx_valid) begin
                    if (q.size() > 0) chk("tx_data", 128'(tx_data), 128'(q[0]));
                    else              chk("model_queue_empty", 128'(1), 128'(0));
                end
                if (hold_prev && tx_valid)
                    chk("tx_data_stable", 128'(tx_data), 128'(prev_data));
            end

            @(posedge clk);
            was_busy = m_busy;
            if (!rst_n) begin
                m_busy = 1'b0; m_cv = 1'b0; m_chal = '0; m_k = 0;
                q.delete();
                hold_prev = 1'b0;
            end else begin
                hold_prev = tx_valid && !tx_ready;
                prev_data = tx_data;
                if (lfsr_enable) en_cnt++;
                if (tx_valid && tx_ready) begin
                    rx_cnt++;
                    if (rx_cnt <= NBYTES) rx = {rx[119:0], tx_data};
                    else                  sum_byte = tx_data;
                end
                if (!was_busy) begin
                    if (start) begin
                        m_busy = 1'b1; m_cv = 1'b0; m_k = 1;
                        for (int i = 0; i < STEPS; i++) m_lfsr = lfsr_step(m_lfsr);
                        rx_cnt = 0; en_cnt = 0;
                    end
                end else begin
                    if (m_k == STEPS + 1) begin
                        m_chal = m_lfsr;
                        x = 8'h00;
                        for (int i = 0; i < NBYTES; i++) begin
                            q.push_back(m_lfsr[127 - 8*i -: 8]);
                            x ^= m_lfsr[127 - 8*i -: 8];
                        end
`ifdef CHALLENGE_CHECKSUM_EN
                        q.push_back(x);
`endif
                    end else if (m_k >= STEPS + 2 && tx_ready) begin
                        void'(q.pop_front());
                        if (q.size() == 0) begin
                            m_busy = 1'b0;
                            m_cv   = 1'b1;
                            chk("handshakes", 128'(rx_cnt), 128'(NB_EXP));
                            chk("enable_cycles", 128'(en_cnt), 128'(STEPS));
                            chk("bytes_vs_challenge", rx, m_chal);
`ifdef CHALLENGE_CHECKSUM_EN
                            x = 8'h00;
                            for (int i = 0; i < NBYTES; i++) x ^= rx[127 - 8*i -: 8];
                            chk("checksum_byte", 128'(sum_byte), 128'(x));
`endif
                        end
                    end
                    m_k++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_challenge(input bit rnd, input bit keep, input int abort_at);
        bit done;
        start    = 1'b1;
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        if (!keep) start = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (abort_at > 0 && rx_cnt >= abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk("async_rst_busy",  128'(busy), 128'(0));
                chk("async_rst_valid", 128'(tx_valid), 128'(0));
                chk("async_rst_data",  128'(tx_data), 128'(0));
                chk("async_rst_chal",  challenge, 128'(0));
                chk("async_rst_cv",    128'(cv), 128'(0));
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                done = 1'b1;
            end else if (!busy && cv) begin
                done = 1'b1;
            end else begin
                tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(posedge clk); #1;
            end
        end
        if (!done) chk("challenge_timeout", 128'(0), 128'(1));
        tx_ready = 1'b0;
    endtask

    initial begin : stim
        int           n_en1;
        int           nb1;
        logic [7:0]   first1;
        logic [127:0] prev;
        bit           got;
        rst_n = 1'b0; env_rst_n = 1'b0;
        start = 1'b0; start1 = 1'b0; tx_ready = 1'b0; tx_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 env_rst_n = 1'b1;
        chk("reset_busy",  128'(busy), 128'(0));
        chk("reset_chal",  challenge, 128'(0));
        chk("model_pin_step1", lfsr_step(SEED), SEED_S1);
        @(posedge clk); #1 rst_n = 1'b1;

        // STEPS=1 instance against hand-computed literals
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        n_en1 = 0; nb1 = 0; first1 = 8'h00; got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (en1) n_en1++;
            if (valid1) begin
                if (nb1 == 0) first1 = data1;
                nb1++;
            end
            if (cv1) got = 1'b1;
        end
        chk("one_cv_seen",    128'(got), 128'(1));
        chk("one_en_pulses",  128'(n_en1), 128'(1));
        chk("one_first_byte", 128'(first1), 128'(8'h59));
        chk("one_challenge",  chal1, SEED_S1);
        chk("one_bytes",      128'(nb1), 128'(NB_EXP));
        chk("one_busy_low",   128'(busy1), 128'(0));

        // Full-length challenge, no backpressure
        run_challenge(1'b0, 1'b0, 0);
        // Random backpressure with random idle gaps
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            run_challenge(1'b1, 1'b0, 0);
        end
        // start held through the whole transaction
        run_challenge(1'b0, 1'b1, 0);
        prev = challenge;
        run_challenge(1'b1, 1'b0, 0);
        tests++;
        if (challenge === prev) begin
            fails++;
            $display("FAIL new_challenge_differs: got %h, expected value different from %h", challenge, prev);
        end
        // Reset after 5 bytes, then the sequence continues
        run_challenge(1'b0, 1'b0, 5);
        @(posedge clk); #1;
        run_challenge(1'b1, 1'b0, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_challenge_issuer
`default_nettype wire
